// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front end: sample counter width, default
// sample word width and the loader state encoding.
package fft_pkg;

   localparam int SAMPLE_CNT_W   = 12;
   localparam int DEFAULT_DATA_W = 16;

   typedef enum logic [1:0] {
      CAPTURE,
      FULL,
      DRAIN,
      DONE
   } loader_state_t;

endpackage

// File: rtl/sample_ram.sv
// Frame buffer for sample_loader: one write port, one synchronous read port
// with 1-cycle latency; both ports are gated by ce.
module sample_ram
   import fft_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = SAMPLE_CNT_W
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              ce,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (ce && we) mem[waddr] <= wdata;
   end

   // Only the read register is reset; array contents survive reset.
   always_ff @(posedge clk) begin
      if (!nrst)           rdata <= '0;
      else if (ce && re)   rdata <= mem[raddr];
   end

endmodule

// File: rtl/sample_loader.sv
// Captures a frame of sample_num samples into the sample RAM, then drains it
// to the cache on drain_en. Optional sticky overflow flag: SAMPLE_LOADER_OVF_EN.
module sample_loader
   import fft_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = SAMPLE_CNT_W
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              ce,
   input  logic [ADDR_W-1:0] sample_num,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   input  logic              drain_en,
   input  logic              calc_end,
   output logic              data_loaded,
   output logic              c_valid,
   output logic [ADDR_W-1:0] c_addr,
   output logic [DATA_W-1:0] c_data,
   output logic              data_to_cache_loaded
`ifdef SAMPLE_LOADER_OVF_EN
   ,
   output logic              ovf
`endif
);

   localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

   loader_state_t   state;
   logic [ADDR_W:0] wr_cnt;
   logic [ADDR_W:0] rd_cnt;
   logic [ADDR_W:0] n_len;
   logic [ADDR_W:0] len_in;
   logic [ADDR_W:0] len_cur;
   logic            accept;
   logic            last_wr;
   logic            rd_issue;

   // A zero frame length selects the full 2^ADDR_W buffer.
   assign len_in   = (sample_num == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, sample_num};
   assign len_cur  = (wr_cnt == '0) ? len_in : n_len;
   assign accept   = (state == CAPTURE) && s_valid && s_ready && ce;
   assign last_wr  = (wr_cnt == len_cur - ONE);
   assign rd_issue = (state == DRAIN) && ce && drain_en && (rd_cnt != n_len);

   sample_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .nrst  (nrst),
      .ce    (ce),
      .we    (accept),
      .waddr (wr_cnt[ADDR_W-1:0]),
      .wdata (s_data),
      .re    (rd_issue),
      .raddr (rd_cnt[ADDR_W-1:0]),
      .rdata (c_data)
   );

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state                <= CAPTURE;
         s_ready              <= 1'b0;
         data_loaded          <= 1'b0;
         c_valid              <= 1'b0;
         c_addr               <= '0;
         data_to_cache_loaded <= 1'b0;
         wr_cnt               <= '0;
         rd_cnt               <= '0;
         n_len                <= '0;
      end else begin
         // c_valid is a strobe: it updates even when ce=0 so it never repeats.
         c_valid <= rd_issue;
         if (ce) begin
            case (state)
               CAPTURE: begin
                  s_ready <= 1'b1;
                  if (accept) begin
                     if (wr_cnt == '0) n_len <= len_in;
                     wr_cnt <= wr_cnt + ONE;
                     if (last_wr) begin
                        state       <= FULL;
                        s_ready     <= 1'b0;
                        data_loaded <= 1'b1;
                     end
                  end
               end
               FULL: begin
                  if (drain_en) begin
                     state       <= DRAIN;
                     data_loaded <= 1'b0;
                     rd_cnt      <= '0;
                  end
               end
               DRAIN: begin
                  if (rd_issue) begin
                     rd_cnt <= rd_cnt + ONE;
                     c_addr <= rd_cnt[ADDR_W-1:0];
                  end else if (rd_cnt == n_len) begin
                     state                <= DONE;
                     data_to_cache_loaded <= 1'b1;
                  end
               end
               DONE: begin
                  if (calc_end) begin
                     state                <= CAPTURE;
                     data_to_cache_loaded <= 1'b0;
                     wr_cnt               <= '0;
                     s_ready              <= 1'b1;
                  end
               end
               default: state <= CAPTURE;
            endcase
         end
      end
   end

`ifdef SAMPLE_LOADER_OVF_EN
   always_ff @(posedge clk) begin
      if (!nrst)
         ovf <= 1'b0;
      else if (ce && s_valid && !s_ready && (state != CAPTURE))
         ovf <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_sample_loader.sv
// Self-checking bench for sample_loader: table of frame scenarios plus
// hand-written reset, early-drain and stall sequences; scoreboard on c_*.
module tb_sample_loader;

   localparam int DW = 16;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          ce = 1'b1;
   logic [AW-1:0] sample_num = '0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          drain_en = 1'b0;
   logic          calc_end = 1'b0;
   logic          s_ready;
   logic          data_loaded;
   logic          c_valid;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_data;
   logic          data_to_cache_loaded;
`ifdef SAMPLE_LOADER_OVF_EN
   logic          ovf;
`endif

   int total = 0;
   int bad = 0;
   int strobe_cnt = 0;
   int frame_start = 0;
   logic [AW+DW-1:0] sb [$];
   logic [AW+DW-1:0] e_word;
   logic ce_q = 1'b1;
   logic den_q = 1'b0;

   typedef struct {
      logic [AW-1:0] sn;
      logic [DW-1:0] base;
      bit            tog;
      bit            pause;
      int            exp_len;
   } vec_t;
   vec_t vecs [5];

   always #5 clk = ~clk;

   sample_loader #(
      .DATA_W (DW),
      .ADDR_W (AW)
   ) dut (
      .clk                  (clk),
      .nrst                 (nrst),
      .ce                   (ce),
      .sample_num           (sample_num),
      .s_valid              (s_valid),
      .s_data               (s_data),
      .s_ready              (s_ready),
      .drain_en             (drain_en),
      .calc_end             (calc_end),
      .data_loaded          (data_loaded),
      .c_valid              (c_valid),
      .c_addr               (c_addr),
      .c_data               (c_data),
      .data_to_cache_loaded (data_to_cache_loaded)
`ifdef SAMPLE_LOADER_OVF_EN
      ,
      .ovf                  (ovf)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobes may only follow an edge where both ce and drain_en were high.
   always @(posedge clk) begin
      ce_q  <= ce;
      den_q <= drain_en;
   end

   always @(negedge clk) begin
      if (!ce_q || !den_q) chk("quiet_c_valid", c_valid, 0);
      if (c_valid === 1'b1) begin
         strobe_cnt++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_strobe: addr %0h data %0h with empty scoreboard", c_addr, c_data);
         end else begin
            e_word = sb.pop_front();
            chk("c_addr", c_addr, e_word[AW+DW-1:DW]);
            chk("c_data", c_data, e_word[DW-1:0]);
         end
      end
   end

   task automatic capture(input logic [AW-1:0] sn, input logic [DW-1:0] base,
                          input int exp_len, input int nsend);
      sample_num  = sn;
      frame_start = strobe_cnt;
      for (int k = 0; k < 20 && s_ready !== 1'b1; k++) tick();
      chk("ready_wait", s_ready, 1);
      for (int i = 0; i < nsend; i++) begin
         s_valid = 1'b1;
         s_data  = base + DW'(i);
         chk("cap_ready", s_ready, 1);
         if (i == exp_len - 1) chk("loaded_early", data_loaded, 0);
         if (nsend == exp_len) sb.push_back({AW'(i), base + DW'(i)});
         tick();
         // The frame length must stay latched from the first accept.
         if (i == 0) sample_num = sn + 12'd3;
      end
      s_valid = 1'b0;
      if (nsend == exp_len) begin
         chk("loaded", data_loaded, 1);
         chk("ready_drop", s_ready, 0);
      end
   endtask

   task automatic drain(input int n, input bit tog, input bit pause);
      bit done;
      done = 1'b0;
      for (int c = 0; c < n * 4 + 40 && !done; c++) begin
         ce       = tog ? (c % 2 == 1) : 1'b1;
         drain_en = !(pause && c >= 9 && c < 12);
         tick();
         if (data_to_cache_loaded === 1'b1) done = 1'b1;
      end
      ce       = 1'b1;
      drain_en = 1'b0;
      chk("drain_done", done, 1);
      chk("drain_count", strobe_cnt - frame_start, n);
      chk("sb_drained", sb.size(), 0);
      chk("loaded_clear", data_loaded, 0);
   endtask

   task automatic finish_frame();
      calc_end = 1'b1;
      tick();
      calc_end = 1'b0;
      chk("dtcl_clear", data_to_cache_loaded, 0);
      chk("rearm_ready", s_ready, 1);
   endtask

   task automatic reset_checks();
      chk("rst_s_ready", s_ready, 0);
      chk("rst_loaded", data_loaded, 0);
      chk("rst_c_valid", c_valid, 0);
      chk("rst_c_addr", c_addr, 0);
      chk("rst_c_data", c_data, 0);
      chk("rst_dtcl", data_to_cache_loaded, 0);
`ifdef SAMPLE_LOADER_OVF_EN
      chk("rst_ovf", ovf, 0);
`endif
   endtask

   initial begin
      vecs[0] = '{12'd8,  16'h0011, 1'b0, 1'b0, 8};
      vecs[1] = '{12'd16, 16'h0100, 1'b1, 1'b1, 16};
      vecs[2] = '{12'd1,  16'hBEEF, 1'b0, 1'b0, 1};
      vecs[3] = '{12'd0,  16'h2000, 1'b0, 1'b0, 4096};
      vecs[4] = '{12'd5,  16'hFFFD, 1'b1, 1'b0, 5};

      nrst = 1'b0;
      tick();
      tick();
      reset_checks();
      nrst = 1'b1;
      tick();
      chk("ready_after_rst", s_ready, 1);

      // Basic frame of 8, then a 9th sample and a stray calc_end in FULL.
      capture(12'd8, 16'h0001, 8, 8);
      s_valid  = 1'b1;
      s_data   = 16'hDEAD;
      calc_end = 1'b1;
      repeat (3) begin
         tick();
         chk("no_9th_ready", s_ready, 0);
         chk("hold_loaded", data_loaded, 1);
         chk("calc_end_ignored", data_to_cache_loaded, 0);
      end
      s_valid  = 1'b0;
      calc_end = 1'b0;
`ifdef SAMPLE_LOADER_OVF_EN
      chk("ovf_set", ovf, 1);
`endif
      drain(8, 1'b0, 1'b0);
      finish_frame();
`ifdef SAMPLE_LOADER_OVF_EN
      chk("ovf_sticky", ovf, 1);
`endif

      for (int v = 0; v < 5; v++) begin
         capture(vecs[v].sn, vecs[v].base, vecs[v].exp_len, vecs[v].exp_len);
         drain(vecs[v].exp_len, vecs[v].tog, vecs[v].pause);
         finish_frame();
      end

      // drain_en already high when FULL is entered.
      drain_en = 1'b1;
      capture(12'd4, 16'h4000, 4, 4);
      drain(4, 1'b0, 1'b0);
      finish_frame();

      // Reset after 5 of 8 samples discards the partial frame.
      capture(12'd8, 16'h7000, 8, 5);
      nrst = 1'b0;
      tick();
      tick();
      reset_checks();
      nrst = 1'b1;
      tick();
      chk("ready_after_rst2", s_ready, 1);
      capture(12'd8, 16'h0A00, 8, 8);
      drain(8, 1'b0, 1'b0);
      finish_frame();

      chk("sb_final_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
